// File: rtl/xix_prefix_sequencer.sv
// xix_prefix_sequencer
//
// Sequences the DD/FD (IX/IY) prefixed instruction path. It latches which
// index prefix is active, runs the 5-bit execution phase timer XPT, drives
// the XIX decoder bank (enable / is_Y), and acts on the bank's OR-reduced
// strobes.
//
// Ports
//   clock          system clock, all state changes on the rising edge
//   notReset       synchronous active-low reset
//   wait_n         0 = stall, every register holds (reset still acts)
//   fetch_done     one-cycle pulse, opcode is valid
//   opcode[7:0]    fetched opcode byte
//   PR_Reset_XPT   decoder request: clear XPT
//   P2_Set_CM1     decoder request: end instruction, return to M1
//   P2_Reset_XIX   clear the IX prefix latch
//   P2_Reset_XIY   clear the IY prefix latch
//   XPT[4:0]       execution phase count
//   notXPT[4:0]    bitwise complement of XPT
//   enable         EXEC state with a prefix latched
//   is_Y           IY prefix active (equals XIY)
//   XIX, XIY       prefix latches
//   CM1            high in M1 and PREFIX states
//   int_block      cycle follows a prefix; interrupts must not be taken
//   xpt_overflow   sticky: XPT ran into XPT_MAX without a strobe
//
// Every output is a register or a decode of registered state; there is no
// combinational path from any input to any output.

module xix_prefix_sequencer #(
  parameter int         XPT_MAX   = 31,
  parameter logic [7:0] PREFIX_DD = 8'hDD,
  parameter logic [7:0] PREFIX_FD = 8'hFD
) (
  input  logic       clock,
  input  logic       notReset,
  input  logic       wait_n,
  input  logic       fetch_done,
  input  logic [7:0] opcode,
  input  logic       PR_Reset_XPT,
  input  logic       P2_Set_CM1,
  input  logic       P2_Reset_XIX,
  input  logic       P2_Reset_XIY,
  output logic [4:0] XPT,
  output logic [4:0] notXPT,
  output logic       enable,
  output logic       is_Y,
  output logic       XIX,
  output logic       XIY,
  output logic       CM1,
  output logic       int_block,
  output logic       xpt_overflow
);

  localparam logic [4:0] XPT_LIMIT = XPT_MAX[4:0];
  // ED-prefixed instructions have no indexed form; an ED after DD/FD
  // cancels the pending index prefix.
  localparam logic [7:0] OPC_ED = 8'hED;

  typedef enum logic [1:0] {
    ST_M1     = 2'd0,
    ST_PREFIX = 2'd1,
    ST_EXEC   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] xpt_q, xpt_d;
  logic       xix_q, xix_d;
  logic       xiy_q, xiy_d;
  logic       int_block_q, int_block_d;
  logic       overflow_q, overflow_d;

  always_comb begin
    state_d     = state_q;
    xpt_d       = xpt_q;
    xix_d       = xix_q;
    xiy_d       = xiy_q;
    int_block_d = int_block_q;
    overflow_d  = overflow_q;

    if (wait_n) begin
      // Latch clears are honoured in every state. A prefix fetched in the
      // same cycle is the newer information, so the case below overrides.
      if (P2_Reset_XIX) xix_d = 1'b0;
      if (P2_Reset_XIY) xiy_d = 1'b0;

      case (state_q)
        ST_M1, ST_PREFIX: begin
          if (fetch_done) begin
            if (opcode == PREFIX_DD) begin
              xix_d       = 1'b1;
              xiy_d       = 1'b0;
              state_d     = ST_PREFIX;
              int_block_d = 1'b1;
            end else if (opcode == PREFIX_FD) begin
              xix_d       = 1'b0;
              xiy_d       = 1'b1;
              state_d     = ST_PREFIX;
              int_block_d = 1'b1;
            end else begin
              state_d     = ST_EXEC;
              xpt_d       = 5'd0;
              int_block_d = 1'b0;
              if (opcode == OPC_ED) begin
                xix_d = 1'b0;
                xiy_d = 1'b0;
              end
            end
          end
        end

        ST_EXEC: begin
          // Ending the instruction outranks a plain XPT clear; both yield
          // XPT=0, but only P2_Set_CM1 leaves EXEC.
          if (P2_Set_CM1) begin
            state_d = ST_M1;
            xpt_d   = 5'd0;
          end else if (PR_Reset_XPT) begin
            xpt_d = 5'd0;
          end else if (xpt_q == XPT_LIMIT) begin
            overflow_d = 1'b1;
          end else begin
            xpt_d = xpt_q + 5'd1;
          end
        end

        default: begin
          state_d = ST_M1;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!notReset) begin
      state_q     <= ST_M1;
      xpt_q       <= 5'd0;
      xix_q       <= 1'b0;
      xiy_q       <= 1'b0;
      int_block_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      xpt_q       <= xpt_d;
      xix_q       <= xix_d;
      xiy_q       <= xiy_d;
      int_block_q <= int_block_d;
      overflow_q  <= overflow_d;
    end
  end

  assign XPT          = xpt_q;
  assign notXPT       = ~xpt_q;
  assign XIX          = xix_q;
  assign XIY          = xiy_q;
  assign is_Y         = xiy_q;
  assign enable       = (state_q == ST_EXEC) && (xix_q || xiy_q);
  assign CM1          = (state_q != ST_EXEC);
  assign int_block    = int_block_q;
  assign xpt_overflow = overflow_q;

endmodule
